// File: rtl/if_id_buffer.sv
// if_id_buffer: two-entry instruction buffer between fetch (IF) and decode (ID).
// Decouples fetch from decode stalls. Discards wrong-path instructions when a
// redirect arrives. Presents the head instruction together with its decoded
// field slices.
//
// Optional feature macro: IF_ID_BUF_STATS_EN
//   When defined, this builds the stall and flush event counters.
//   When undefined, no counter registers exist and STALL_CNT / FLUSH_CNT read 0.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid and ready are both high and
//   FLUSH is low. IF_READY is a function of registered state only, so it never
//   combinationally depends on ID_READY or IF_VALID.
module if_id_buffer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        IF_VALID,
   output logic        IF_READY,
   input  logic [31:0] IF_PC,
   input  logic [31:0] IF_INSTR,
   input  logic        FLUSH,
   output logic        ID_VALID,
   input  logic        ID_READY,
   output logic [31:0] ID_PC,
   output logic [31:0] ID_INSTR,
   output logic [24:0] ID_IMM_RAW,
   output logic [6:0]  ID_OPCODE,
   output logic [4:0]  ID_RD,
   output logic [2:0]  ID_FUNCT3,
   output logic [4:0]  ID_RS1,
   output logic [4:0]  ID_RS2,
   output logic [6:0]  ID_FUNCT7,
   output logic [1:0]  OCCUPANCY,
   output logic [31:0] STALL_CNT,
   output logic [31:0] FLUSH_CNT
);

   logic [1:0]  count_q, count_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic [31:0] pc_mem_q [2];
   logic [31:0] pc_mem_d [2];
   logic [31:0] instr_mem_q [2];
   logic [31:0] instr_mem_d [2];
   logic        push;
   logic        pop;

   assign IF_READY  = (count_q != 2'd2);
   assign ID_VALID  = (count_q != 2'd0);
   assign OCCUPANCY = count_q;

   // Next-state: a flush clears everything, otherwise apply the push and/or the pop
   always_comb begin
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      pc_mem_d    = pc_mem_q;
      instr_mem_d = instr_mem_q;
      push        = IF_VALID & IF_READY & ~FLUSH;
      pop         = ID_VALID & ID_READY & ~FLUSH;
      if (FLUSH) begin
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
      end else begin
         if (push) begin
            pc_mem_d[wr_ptr_q]    = IF_PC;
            instr_mem_d[wr_ptr_q] = IF_INSTR;
            wr_ptr_d              = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // Buffer state registers. Reset empties the buffer without needing a clock.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         count_q  <= 2'd0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            pc_mem_q[i]    <= 32'h0;
            instr_mem_q[i] <= 32'h0;
         end
      end else begin
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         pc_mem_q    <= pc_mem_d;
         instr_mem_q <= instr_mem_d;
      end
   end

   // Head presentation. An empty buffer shows a NOP at the reset PC, so decode
   // sees a harmless instruction whenever ID_VALID is low.
   always_comb begin
      ID_PC    = RESET_PC;
      ID_INSTR = NOP_INSTR;
      if (ID_VALID) begin
         ID_PC    = pc_mem_q[rd_ptr_q];
         ID_INSTR = instr_mem_q[rd_ptr_q];
      end
   end

   assign ID_IMM_RAW = ID_INSTR[31:7];
   assign ID_OPCODE  = ID_INSTR[6:0];
   assign ID_RD      = ID_INSTR[11:7];
   assign ID_FUNCT3  = ID_INSTR[14:12];
   assign ID_RS1     = ID_INSTR[19:15];
   assign ID_RS2     = ID_INSTR[24:20];
   assign ID_FUNCT7  = ID_INSTR[31:25];

`ifdef IF_ID_BUF_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Event counters. Both wrap naturally at 32 bits.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (IF_VALID && !IF_READY) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (FLUSH) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   // Counter registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         stall_cnt_q <= 32'h0;
         flush_cnt_q <= 32'h0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign STALL_CNT = stall_cnt_q;
   assign FLUSH_CNT = flush_cnt_q;
`else
   assign STALL_CNT = 32'h0;
   assign FLUSH_CNT = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Testbench for if_id_buffer. The reference model is a queue of {pc, instr}
// entries with a depth limit of two, plus two event counters.
module tb_if_id_buffer;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        if_valid = 1'b0;
   logic [31:0] if_pc    = 32'h0;
   logic [31:0] if_instr = 32'h0;
   logic        flush    = 1'b0;
   logic        id_ready = 1'b0;
   logic        if_ready;
   logic        id_valid;
   logic [31:0] id_pc, id_instr, stall_cnt, flush_cnt;
   logic [24:0] id_imm_raw;
   logic [6:0]  id_opcode, id_funct7;
   logic [4:0]  id_rd, id_rs1, id_rs2;
   logic [2:0]  id_funct3;
   logic [1:0]  occupancy;

   if_id_buffer #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
      .CLK(clk), .RESET(rst),
      .IF_VALID(if_valid), .IF_READY(if_ready), .IF_PC(if_pc), .IF_INSTR(if_instr),
      .FLUSH(flush),
      .ID_VALID(id_valid), .ID_READY(id_ready), .ID_PC(id_pc), .ID_INSTR(id_instr),
      .ID_IMM_RAW(id_imm_raw), .ID_OPCODE(id_opcode), .ID_RD(id_rd),
      .ID_FUNCT3(id_funct3), .ID_RS1(id_rs1), .ID_RS2(id_rs2), .ID_FUNCT7(id_funct7),
      .OCCUPANCY(occupancy), .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
   );

   // ---------------- reference model / scoreboard ----------------
   logic [63:0] exp_q[$];
   logic [31:0] m_stall;
   logic [31:0] m_flush;
   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [31:0] exp_pc();
      return (exp_q.size() > 0) ? exp_q[0][63:32] : RST_PC;
   endfunction

   function automatic logic [31:0] exp_instr();
      return (exp_q.size() > 0) ? exp_q[0][31:0] : NOP;
   endfunction

   function automatic logic [31:0] exp_stall();
`ifdef IF_ID_BUF_STATS_EN
      return m_stall;
`else
      return 32'h0;
`endif
   endfunction

   function automatic logic [31:0] exp_flushes();
`ifdef IF_ID_BUF_STATS_EN
      return m_flush;
`else
      return 32'h0;
`endif
   endfunction

   // ---------------- driver tasks ----------------
   // One clock cycle: drive the inputs, let the edge happen, advance the model,
   // then settle 1 time unit past the edge so the caller can sample outputs.
   task automatic cycle(input logic vld, input logic [31:0] pc, input logic [31:0] ins,
                        input logic fl, input logic rdy);
      int size_before;
      if_valid = vld;
      if_pc    = pc;
      if_instr = ins;
      flush    = fl;
      id_ready = rdy;
      size_before = exp_q.size();
      @(posedge clk);
      if (vld && size_before == 2) m_stall = m_stall + 32'd1;
      if (fl) begin
         m_flush = m_flush + 32'd1;
         exp_q.delete();
      end else begin
         if (rdy && size_before > 0) void'(exp_q.pop_front());
         if (vld && size_before < 2) exp_q.push_back({pc, ins});
      end
      #1;
   endtask

   task automatic apply_reset();
      rst      = 1'b1;
      if_valid = 1'b0;
      flush    = 1'b0;
      id_ready = 1'b0;
      exp_q.delete();
      m_stall  = 32'h0;
      m_flush  = 32'h0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_tests++;
      if ({id_valid, if_ready, occupancy} !== {1'b0, 1'b1, 2'd0}) begin
         n_fail++;
         $display("FAIL reset_flags: got valid=%b ready=%b occ=%0d, want 0 1 0", id_valid, if_ready, occupancy);
      end
      n_tests++;
      if (id_pc !== RST_PC || id_instr !== NOP) begin
         n_fail++;
         $display("FAIL reset_head: got pc=%h instr=%h, want %h %h", id_pc, id_instr, RST_PC, NOP);
      end
      n_tests++;
      if ({id_imm_raw, id_opcode, id_rd, id_funct3, id_rs1, id_rs2, id_funct7} !==
          {25'h0, 7'h13, 5'h0, 3'h0, 5'h0, 5'h0, 7'h0}) begin
         n_fail++;
         $display("FAIL reset_fields: got imm=%h op=%h rd=%h f3=%h rs1=%h rs2=%h f7=%h, want op=13 rest 0",
                  id_imm_raw, id_opcode, id_rd, id_funct3, id_rs1, id_rs2, id_funct7);
      end
      n_tests++;
      if (stall_cnt !== 32'h0 || flush_cnt !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_counters: got %h %h, want 0 0", stall_cnt, flush_cnt);
      end
      apply_reset();
   endtask

   task automatic test_single();
      logic [31:0] ins;
      ins = 32'hFFF0_0093;
      cycle(1'b1, 32'h0, ins, 1'b0, 1'b1);
      n_tests++;
      if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== ins) begin
         n_fail++;
         $display("FAIL single_visible: got valid=%b pc=%h instr=%h, want 1 0 %h", id_valid, id_pc, id_instr, ins);
      end
      n_tests++;
      if (id_imm_raw !== 25'((ins >> 7) & 32'h01FF_FFFF) || id_rd !== 5'd1 || id_opcode !== 7'h13) begin
         n_fail++;
         $display("FAIL single_fields: got imm=%h rd=%0d op=%h, want imm=%h rd=1 op=13",
                  id_imm_raw, id_rd, id_opcode, 25'((ins >> 7) & 32'h01FF_FFFF));
      end
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      n_tests++;
      if (id_valid !== 1'b0 || occupancy !== 2'd0) begin
         n_fail++;
         $display("FAIL single_pop: got valid=%b occ=%0d, want 0 0", id_valid, occupancy);
      end
   endtask

   task automatic test_fill_stall();
      cycle(1'b1, 32'h4, 32'h0040_0113, 1'b0, 1'b0);
      n_tests++;
      if (occupancy !== 2'd1 || id_pc !== 32'h4 || if_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_first: got occ=%0d pc=%h ready=%b, want 1 4 1", occupancy, id_pc, if_ready);
      end
      cycle(1'b1, 32'h8, 32'h0080_0193, 1'b0, 1'b0);
      n_tests++;
      if (occupancy !== 2'd2 || if_ready !== 1'b0 || id_pc !== 32'h4) begin
         n_fail++;
         $display("FAIL fill_second: got occ=%0d ready=%b pc=%h, want 2 0 4", occupancy, if_ready, id_pc);
      end
      cycle(1'b1, 32'hC, 32'h00C0_0213, 1'b0, 1'b0);
      n_tests++;
      if (occupancy !== 2'd2 || id_pc !== 32'h4 || id_instr !== 32'h0040_0113) begin
         n_fail++;
         $display("FAIL fill_reject: got occ=%0d pc=%h instr=%h, want 2 4 00400113", occupancy, id_pc, id_instr);
      end
   endtask

   task automatic test_release();
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      n_tests++;
      if (id_pc !== 32'h8 || occupancy !== 2'd1 || if_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL release_first: got pc=%h occ=%0d ready=%b, want 8 1 1", id_pc, occupancy, if_ready);
      end
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      n_tests++;
      if (id_valid !== 1'b0 || occupancy !== 2'd0 || id_pc !== RST_PC) begin
         n_fail++;
         $display("FAIL release_second: got valid=%b occ=%0d pc=%h, want 0 0 %h", id_valid, occupancy, id_pc, RST_PC);
      end
   endtask

   task automatic test_flush();
      cycle(1'b1, 32'h20, 32'h1111_1033, 1'b0, 1'b0);
      cycle(1'b1, 32'h24, 32'h2222_2033, 1'b0, 1'b0);
      cycle(1'b1, 32'h10, 32'h3333_3033, 1'b1, 1'b1);
      n_tests++;
      if (occupancy !== 2'd0 || id_instr !== NOP || id_valid !== 1'b0 || if_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_clear: got occ=%0d instr=%h valid=%b ready=%b, want 0 %h 0 1",
                  occupancy, id_instr, id_valid, if_ready, NOP);
      end
      cycle(1'b1, 32'h14, 32'h4444_4033, 1'b0, 1'b0);
      n_tests++;
      if (occupancy !== 2'd1 || id_pc !== 32'h14 || id_instr !== 32'h4444_4033) begin
         n_fail++;
         $display("FAIL flush_refill: got occ=%0d pc=%h instr=%h, want 1 14 44444033", occupancy, id_pc, id_instr);
      end
   endtask

   task automatic test_async_reset();
      // One entry is held at this point; assert reset away from any clock edge.
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (id_valid !== 1'b0 || occupancy !== 2'd0 || if_ready !== 1'b1 || id_pc !== RST_PC) begin
         n_fail++;
         $display("FAIL async_reset: got valid=%b occ=%0d ready=%b pc=%h, want 0 0 1 %h",
                  id_valid, occupancy, if_ready, id_pc, RST_PC);
      end
      apply_reset();
      // First push accepted in the first cycle with reset low.
      cycle(1'b1, 32'h40, 32'h0050_0293, 1'b0, 1'b0);
      n_tests++;
      if (id_valid !== 1'b1 || id_pc !== 32'h40) begin
         n_fail++;
         $display("FAIL reset_release_push: got valid=%b pc=%h, want 1 40", id_valid, id_pc);
      end
   endtask

   task automatic test_stats();
      apply_reset();
      cycle(1'b1, 32'h100, 32'h0000_0013, 1'b0, 1'b0);
      cycle(1'b1, 32'h104, 32'h0000_0013, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'h108, 32'h0000_0013, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      n_tests++;
`ifdef IF_ID_BUF_STATS_EN
      if (stall_cnt !== 32'd3 || flush_cnt !== 32'd2) begin
         n_fail++;
         $display("FAIL stats_counts: got stall=%0d flush=%0d, want 3 2", stall_cnt, flush_cnt);
      end
`else
      if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL stats_counts: got stall=%0d flush=%0d, want 0 0", stall_cnt, flush_cnt);
      end
`endif
   endtask

   task automatic test_random();
      logic [31:0] pc;
      logic [31:0] e_ins;
      int errs;
      apply_reset();
      pc = 32'h1000;
      errs = 0;
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 3) != 0), pc, $urandom(), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 2) != 0));
         pc = pc + 32'd4;
         e_ins = exp_instr();
         n_tests++;
         if ({id_valid, if_ready, occupancy} !==
             {exp_q.size() != 0, exp_q.size() != 2, 2'(exp_q.size())}) begin
            n_fail++;
            if (errs++ < 10)
               $display("FAIL rand_flags[%0d]: got valid=%b ready=%b occ=%0d, want occ=%0d",
                        i, id_valid, if_ready, occupancy, exp_q.size());
         end
         n_tests++;
         if (id_pc !== exp_pc() || id_instr !== e_ins) begin
            n_fail++;
            if (errs++ < 10)
               $display("FAIL rand_head[%0d]: got pc=%h instr=%h, want %h %h", i, id_pc, id_instr, exp_pc(), e_ins);
         end
         n_tests++;
         if (id_imm_raw !== 25'(e_ins >> 7) || id_opcode !== 7'(e_ins) ||
             id_rd !== 5'(e_ins >> 7) || id_funct3 !== 3'(e_ins >> 12) ||
             id_rs1 !== 5'(e_ins >> 15) || id_rs2 !== 5'(e_ins >> 20) ||
             id_funct7 !== 7'(e_ins >> 25)) begin
            n_fail++;
            if (errs++ < 10)
               $display("FAIL rand_fields[%0d]: got imm=%h op=%h rd=%h f3=%h rs1=%h rs2=%h f7=%h for instr %h",
                        i, id_imm_raw, id_opcode, id_rd, id_funct3, id_rs1, id_rs2, id_funct7, e_ins);
         end
         n_tests++;
         if (stall_cnt !== exp_stall() || flush_cnt !== exp_flushes()) begin
            n_fail++;
            if (errs++ < 10)
               $display("FAIL rand_counters[%0d]: got %0d %0d, want %0d %0d",
                        i, stall_cnt, flush_cnt, exp_stall(), exp_flushes());
         end
      end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      m_stall = 32'h0;
      m_flush = 32'h0;
      test_reset();
      test_single();
      test_fill_stall();
      test_release();
      test_flush();
      test_async_reset();
      test_stats();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
